// File: rtl/d_latch_bank_pkg.sv
// Shared constants for the d_latch_bank slice.
// Holds the default width and the all-zeros reset bit.
package d_latch_bank_pkg;

    localparam int DEFAULT_WIDTH = 1;

    // Replicated by users to build an all-zeros RESET_VALUE.
    localparam logic RESET_ZERO_BIT = 1'b0;

endpackage

// File: rtl/d_latch_bank_if.sv
// Latch bank signal bundle.
// master drives E/D, slave returns Q/held_valid.
interface d_latch_bank_if
    import d_latch_bank_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             E;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             held_valid;

    modport master (
        output E,
        output D,
        input  Q,
        input  held_valid
    );

    modport slave (
        input  E,
        input  D,
        output Q,
        output held_valid
    );

endinterface

// File: rtl/d_latch_cell.sv
// One bit of emulated transparent latch.
// Ports: clk, rst_n, e (enable), d (data), q (output).
module d_latch_cell #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic e,
    input  logic d,
    output logic q
);

    logic hold;

    // Reset overrides the mux so q tracks the async clear at once.
    always_comb begin
        if (!rst_n) begin
            q = RESET_VALUE;
        end else if (e) begin
            q = d;
        end else begin
            q = hold;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= RESET_VALUE;
        end else if (e) begin
            hold <= d;
        end
    end

endmodule

// File: rtl/d_latch_bank.sv
// Bank of WIDTH flop-based transparent latches.
// Ports: clk, rst_n, bus (slave: E, D in; Q, held_valid out).
module d_latch_bank
    import d_latch_bank_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{RESET_ZERO_BIT}}
) (
    input  logic           clk,
    input  logic           rst_n,
    d_latch_bank_if.slave  bus
);

    logic [WIDTH-1:0] q;
    logic             hv_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        d_latch_cell #(
            .RESET_VALUE (RESET_VALUE[i])
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .e     (bus.E),
            .d     (bus.D[i]),
            .q     (q[i])
        );
    end

    // Sticky flag: set once any edge has sampled E high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hv_q <= 1'b0;
        end else if (bus.E) begin
            hv_q <= 1'b1;
        end
    end

    assign bus.Q          = q;
    assign bus.held_valid = hv_q;

endmodule

// File: tb/tb_d_latch_bank.sv
// Self-checking bench for d_latch_bank.
// Drives a 1-bit and an 8-bit bank against a behavioural model.
module tb_d_latch_bank;

    localparam logic [7:0] RV8 = 8'h96;

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    d_latch_bank_if #(.WIDTH(1)) if1 ();
    d_latch_bank_if #(.WIDTH(8)) if8 ();

    d_latch_bank #(
        .WIDTH       (1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    d_latch_bank #(
        .WIDTH       (8),
        .RESET_VALUE (RV8)
    ) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    // Reference: last value seen on D at an enabled edge since reset,
    // and whether any enabled edge has happened since reset.
    logic [7:0] last_cap8;
    logic       last_cap1;
    logic       seen_en8;
    logic       seen_en1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_cap8 <= RV8;
            last_cap1 <= 1'b0;
            seen_en8  <= 1'b0;
            seen_en1  <= 1'b0;
        end else begin
            if (if8.E === 1'b1) begin
                last_cap8 <= if8.D;
                seen_en8  <= 1'b1;
            end
            if (if1.E === 1'b1) begin
                last_cap1 <= if1.D;
                seen_en1  <= 1'b1;
            end
        end
    end

    function automatic logic [7:0] exp_q8();
        if (!rst_n) return RV8;
        return if8.E ? if8.D : last_cap8;
    endfunction

    function automatic logic exp_q1();
        if (!rst_n) return 1'b0;
        return if1.E ? if1.D : last_cap1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        if1.E = 1'b1; if1.D = 1'b1;
        if8.E = 1'b1; if8.D = 8'hFF;
        #1;
        total_cnt++;
        if (if1.Q !== 1'b0) $display("FAIL rst_q1 got %b want 0", if1.Q);
        else pass_cnt++;
        total_cnt++;
        if (if8.Q !== RV8) $display("FAIL rst_q8 got %h want %h", if8.Q, RV8);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (if1.held_valid !== 1'b0 || if8.held_valid !== 1'b0)
            $display("FAIL rst_hv got %b%b want 00", if1.held_valid, if8.held_valid);
        else pass_cnt++;
        total_cnt++;
        if (if1.Q !== 1'b0) $display("FAIL rst_edge_q1 got %b want 0", if1.Q);
        else pass_cnt++;
        @(negedge clk);
        if1.E = 1'b0; if8.E = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (if1.Q !== 1'b0) $display("FAIL rst_rel_q1 got %b want 0", if1.Q);
        else pass_cnt++;
        total_cnt++;
        if (if8.Q !== RV8) $display("FAIL rst_rel_q8 got %h want %h", if8.Q, RV8);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [1:0] stim [5];
        logic       want [5];
        logic       hv_w [5];
        stim = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b10};
        want = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        hv_w = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if1.E = stim[i][1];
            if1.D = stim[i][0];
            @(posedge clk); #1;
            total_cnt++;
            if (if1.Q !== want[i])
                $display("FAIL basic_q step%0d got %b want %b", i, if1.Q, want[i]);
            else pass_cnt++;
            total_cnt++;
            if (if1.held_valid !== hv_w[i])
                $display("FAIL basic_hv step%0d got %b want %b",
                         i, if1.held_valid, hv_w[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_transparency();
        logic [7:0] pat [4];
        pat = '{8'hA5, 8'h5A, 8'hA5, 8'h5A};
        @(negedge clk);
        if8.E = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if8.D = pat[i];
            #1;
            total_cnt++;
            if (if8.Q !== pat[i])
                $display("FAIL transp_q%0d got %h want %h", i, if8.Q, pat[i]);
            else pass_cnt++;
            #1;
        end
    endtask

    task automatic test_hold_isolation();
        @(negedge clk);
        if8.E = 1'b1; if8.D = 8'h3C;
        @(negedge clk);
        if8.E = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if8.D = (i % 2 == 0) ? 8'h00 : 8'hFF;
            #1;
            total_cnt++;
            if (if8.Q !== 8'h3C)
                $display("FAIL hold_mid%0d got %h want 3c", i, if8.Q);
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if (if8.Q !== 8'h3C)
                $display("FAIL hold_edge%0d got %h want 3c", i, if8.Q);
            else pass_cnt++;
        end
    endtask

    task automatic test_short_pulse();
        @(negedge clk);
        if8.E = 1'b1; if8.D = 8'h11;
        @(negedge clk);
        if8.E = 1'b0;
        #1;
        if8.E = 1'b1; if8.D = 8'hFF;
        #1;
        total_cnt++;
        if (if8.Q !== 8'hFF) $display("FAIL pulse_in got %h want ff", if8.Q);
        else pass_cnt++;
        #2;
        if8.E = 1'b0;
        #1;
        total_cnt++;
        if (if8.Q !== 8'h11) $display("FAIL pulse_out got %h want 11", if8.Q);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (if8.Q !== 8'h11) $display("FAIL pulse_edge got %h want 11", if8.Q);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_hold();
        @(negedge clk);
        if8.E = 1'b1; if8.D = 8'h77;
        @(negedge clk);
        if8.E = 1'b0; if8.D = 8'h00;
        @(posedge clk); #2;
        total_cnt++;
        if (if8.Q !== 8'h77) $display("FAIL mid_pre got %h want 77", if8.Q);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (if8.Q !== RV8) $display("FAIL mid_rst_q got %h want %h", if8.Q, RV8);
        else pass_cnt++;
        total_cnt++;
        if (if8.held_valid !== 1'b0)
            $display("FAIL mid_rst_hv got %b want 0", if8.held_valid);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (if8.Q !== RV8) $display("FAIL mid_rel_q got %h want %h", if8.Q, RV8);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if1.E = 1'($urandom_range(0, 1));
            if1.D = 1'($urandom_range(0, 1));
            if8.E = 1'($urandom_range(0, 1));
            if8.D = 8'($urandom);
            #1;
            total_cnt++;
            if (if8.Q !== exp_q8() || if1.Q !== exp_q1())
                $display("FAIL rnd_comb%0d got %h/%b want %h/%b",
                         i, if8.Q, if1.Q, exp_q8(), exp_q1());
            else pass_cnt++;
            if1.D = 1'($urandom_range(0, 1));
            if8.D = 8'($urandom);
            if ($urandom_range(0, 29) == 0) rst_n = 1'b0;
            #1;
            total_cnt++;
            if (if8.Q !== exp_q8() || if1.Q !== exp_q1())
                $display("FAIL rnd_mid%0d got %h/%b want %h/%b",
                         i, if8.Q, if1.Q, exp_q8(), exp_q1());
            else pass_cnt++;
            rst_n = 1'b1;
            @(posedge clk); #1;
            total_cnt++;
            if (if8.Q !== exp_q8() || if1.Q !== exp_q1())
                $display("FAIL rnd_edge%0d got %h/%b want %h/%b",
                         i, if8.Q, if1.Q, exp_q8(), exp_q1());
            else pass_cnt++;
            total_cnt++;
            if (if8.held_valid !== seen_en8 || if1.held_valid !== seen_en1)
                $display("FAIL rnd_hv%0d got %b%b want %b%b", i,
                         if8.held_valid, if1.held_valid, seen_en8, seen_en1);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_transparency();
        test_hold_isolation();
        test_short_pulse();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
